// File: rtl/pc_ir_status_unit.sv
// pc_ir_status_unit
// Program counter, instruction register and status flag register for the
// LEGv8 datapath. Applies the PS/IL/SL control fields each cycle, runs a
// request/acknowledge fetch handshake with instruction memory and returns
// instruction, status and stall to the control unit.
// Optional feature macro: PC_ALIGN_CHECK_EN -- blocks misaligned PC loads
// and exposes a sticky pc_misalign flag.
module pc_ir_status_unit #(
  parameter int              N        = 64,
  parameter logic [N-1:0]    RESET_PC = {N{1'b0}}
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [1:0]     PS,
  input  logic           IL,
  input  logic           SL,
  input  logic [N-1:0]   constant,
  input  logic [N-1:0]   bus_a,
  input  logic [3:0]     alu_flags,
  input  logic           alu_zero,
  input  logic [31:0]    imem_data,
  input  logic           imem_ack,
  output logic [N-1:0]   imem_addr,
  output logic           imem_req,
  output logic [31:0]    instruction,
  output logic [4:0]     status,
`ifdef PC_ALIGN_CHECK_EN
  output logic           pc_misalign,
`endif
  output logic [N-1:0]   pc,
  output logic [N-1:0]   pc_plus4,
  output logic           stall
);

  localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'b100};

  logic [N-1:0] r_pc;
  logic [N-1:0] r_instr_pc;
  logic [31:0]  r_ir;
  logic [3:0]   r_flags;

  logic         w_stall;
  logic [N-1:0] w_pc_target;
  logic [N-1:0] w_pc_next;
`ifdef PC_ALIGN_CHECK_EN
  logic         w_misalign_load;
  logic         r_misalign;
`endif

  // Word offset scaled to a byte offset; the top two bits fall off.
  function automatic logic [N-1:0] word_to_byte(input logic [N-1:0] off);
    word_to_byte = {off[N-3:0], 2'b00};
  endfunction

  // Handshake: a pending fetch without acknowledge freezes everything.
  assign w_stall  = IL & ~imem_ack;
  assign stall    = w_stall;
  assign imem_req = IL;

  // PC target selection; the relative branch is based on the address of
  // the instruction held in the IR, not the already-advanced PC.
  always_comb begin
    w_pc_target = r_pc;
    case (PS)
      2'b00:   w_pc_target = r_pc;
      2'b01:   w_pc_target = r_pc + PC_STEP;
      2'b10:   w_pc_target = bus_a;
      2'b11:   w_pc_target = r_instr_pc + word_to_byte(constant);
      default: w_pc_target = r_pc;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Reject load targets that are not word aligned; the PC holds instead.
  always_comb begin
    w_misalign_load = 1'b0;
    w_pc_next       = w_pc_target;
    if (PS[1] && (w_pc_target[1:0] != 2'b00)) begin
      w_misalign_load = 1'b1;
      w_pc_next       = r_pc;
    end else begin
      w_misalign_load = 1'b0;
      w_pc_next       = w_pc_target;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (!w_stall && w_misalign_load) begin
      r_misalign <= 1'b1;
    end else begin
      r_misalign <= r_misalign;
    end
  end

  assign pc_misalign = r_misalign;
`else
  // Without alignment checking every target loads unchanged.
  always_comb begin
    w_pc_next = w_pc_target;
  end
`endif

  // PC, IR, instruction address and flags advance on any non-stalled edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_instr_pc <= RESET_PC;
      r_ir       <= 32'h0000_0000;
      r_flags    <= 4'b0000;
    end else if (!w_stall) begin
      r_pc <= w_pc_next;
      if (IL) begin
        r_ir       <= imem_data;
        r_instr_pc <= r_pc;
      end
      if (SL) begin
        r_flags <= alu_flags;
      end
    end
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign instruction = r_ir;
  assign pc_plus4    = r_instr_pc + PC_STEP;
  assign status      = {r_flags, alu_zero};

endmodule

// File: tb/tb_pc_ir_status_unit.sv
// Directed scoreboard bench for pc_ir_status_unit (RESET_PC = 0x40).
module tb_pc_ir_status_unit;

  localparam int SEL_PC    = 0;
  localparam int SEL_IR    = 1;
  localparam int SEL_STAT  = 2;
  localparam int SEL_STALL = 3;
  localparam int SEL_PCP4  = 4;
  localparam int SEL_IADDR = 5;
  localparam int SEL_IREQ  = 6;
  localparam int SEL_MIS   = 7;

  logic        clock;
  logic        reset;
  logic [1:0]  PS;
  logic        IL;
  logic        SL;
  logic [63:0] constant;
  logic [63:0] bus_a;
  logic [3:0]  alu_flags;
  logic        alu_zero;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        stall;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misalign;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pc_ir_status_unit #(.N(64), .RESET_PC(64'h40)) dut (
    .clock(clock), .reset(reset), .PS(PS), .IL(IL), .SL(SL),
    .constant(constant), .bus_a(bus_a), .alu_flags(alu_flags),
    .alu_zero(alu_zero), .imem_data(imem_data), .imem_ack(imem_ack),
    .imem_addr(imem_addr), .imem_req(imem_req), .instruction(instruction),
    .status(status),
`ifdef PC_ALIGN_CHECK_EN
    .pc_misalign(pc_misalign),
`endif
    .pc(pc), .pc_plus4(pc_plus4), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_PC:    observe = pc;
      SEL_IR:    observe = {32'h0, instruction};
      SEL_STAT:  observe = {59'h0, status};
      SEL_STALL: observe = {63'h0, stall};
      SEL_PCP4:  observe = pc_plus4;
      SEL_IADDR: observe = imem_addr;
      SEL_IREQ:  observe = {63'h0, imem_req};
`ifdef PC_ALIGN_CHECK_EN
      SEL_MIS:   observe = {63'h0, pc_misalign};
`endif
      default:   observe = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
    chk_t c;
    c.tag = tag;
    c.sel = sel;
    c.exp = exp;
    q.push_back(c);
  endtask

  task automatic drain();
    chk_t        c;
    logic [63:0] obs;
    while (q.size() > 0) begin
      c   = q.pop_front();
      obs = observe(c.sel);
      n_cmp++;
      assert (obs === c.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", c.tag, obs, c.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; PS = 2'b00; IL = 1'b0; SL = 1'b0;
    constant = 64'h0; bus_a = 64'h0; alu_flags = 4'b0000; alu_zero = 1'b0;
    imem_data = 32'h0; imem_ack = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    expect_val("rst_pc", SEL_PC, 64'h40);
    expect_val("rst_ir", SEL_IR, 64'h0);
    expect_val("rst_status", SEL_STAT, 64'h0);
    expect_val("rst_stall", SEL_STALL, 64'h0);
    expect_val("rst_pcp4", SEL_PCP4, 64'h44);
`ifdef PC_ALIGN_CHECK_EN
    expect_val("rst_mis", SEL_MIS, 64'h0);
`endif
    drain();

    // Release; idle edge plus stray ack with IL low
    reset = 1'b1;
    tick();
    imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
    tick();
    expect_val("idle_pc", SEL_PC, 64'h40);
    expect_val("stray_ack_ir", SEL_IR, 64'h0);
    drain();

    // Fetch with three wait states, SL during the stall
    IL = 1'b1; PS = 2'b01; imem_ack = 1'b0; imem_data = 32'h8B020020;
    SL = 1'b1; alu_flags = 4'b1111;
    #1;
    expect_val("req", SEL_IREQ, 64'h1);
    expect_val("iaddr", SEL_IADDR, 64'h40);
    expect_val("stall_on", SEL_STALL, 64'h1);
    drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("wait_pc", SEL_PC, 64'h40);
      expect_val("wait_stall", SEL_STALL, 64'h1);
      expect_val("wait_flags", SEL_STAT, 64'h0);
      drain();
    end
    SL = 1'b0; imem_ack = 1'b1;
    #1;
    expect_val("ack_stall", SEL_STALL, 64'h0);
    drain();
    tick();
    expect_val("fetch_ir", SEL_IR, 64'h8B020020);
    expect_val("fetch_pc", SEL_PC, 64'h44);
    expect_val("fetch_pcp4", SEL_PCP4, 64'h44);
    drain();

    // Relative branch from instr_pc 0x100
    IL = 1'b0; imem_ack = 1'b0; PS = 2'b10; bus_a = 64'h100;
    tick();
    IL = 1'b1; imem_ack = 1'b1; PS = 2'b01;
    tick();
    expect_val("pre_br_pc", SEL_PC, 64'h104);
    expect_val("pre_br_pcp4", SEL_PCP4, 64'h104);
    drain();
    IL = 1'b0; imem_ack = 1'b0; PS = 2'b11; constant = 64'hFFFFFFFFFFFFFFFE;
    tick();
    expect_val("br_pc", SEL_PC, 64'hF8);
    drain();
    PS = 2'b01;
    tick();
    expect_val("br_inc_pc", SEL_PC, 64'hFC);
    drain();

    // Register branch with link value from instr_pc 0x200
    PS = 2'b10; bus_a = 64'h200;
    tick();
    IL = 1'b1; imem_ack = 1'b1; PS = 2'b01;
    tick();
    IL = 1'b0; imem_ack = 1'b0; PS = 2'b10; bus_a = 64'h1000;
    #1;
    expect_val("blr_link", SEL_PCP4, 64'h204);
    drain();
    tick();
    expect_val("blr_pc", SEL_PC, 64'h1000);
    expect_val("blr_link_after", SEL_PCP4, 64'h204);
    drain();

    // Flag load and live zero
    PS = 2'b00; SL = 1'b1; alu_flags = 4'b1010; alu_zero = 1'b1;
    tick();
    expect_val("flags_load", SEL_STAT, 64'h15);
    drain();
    SL = 1'b0; alu_zero = 1'b0;
    #1;
    expect_val("live_zero", SEL_STAT, 64'h14);
    drain();

    // Fetch, flag load and branch all on one edge; branch uses old instr_pc
    IL = 1'b1; imem_ack = 1'b1; SL = 1'b1; PS = 2'b11; constant = 64'h1;
    alu_flags = 4'b0101; imem_data = 32'hD503201F;
    tick();
    expect_val("combo_pc", SEL_PC, 64'h204);
    expect_val("combo_ir", SEL_IR, 64'hD503201F);
    expect_val("combo_status", SEL_STAT, 64'h0A);
    expect_val("combo_pcp4", SEL_PCP4, 64'h1004);
    drain();

    // Wrap-around of PC+4
    IL = 1'b0; imem_ack = 1'b0; SL = 1'b0; PS = 2'b10; bus_a = 64'hFFFFFFFFFFFFFFFC;
    tick();
    PS = 2'b01;
    tick();
    expect_val("wrap_pc", SEL_PC, 64'h0);
    drain();

    // Misaligned register target
    PS = 2'b10; bus_a = 64'h1002;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    expect_val("mis_pc_hold", SEL_PC, 64'h0);
    expect_val("mis_flag", SEL_MIS, 64'h1);
    drain();
    bus_a = 64'h1000;
    tick();
    expect_val("mis_aligned_pc", SEL_PC, 64'h1000);
    expect_val("mis_sticky", SEL_MIS, 64'h1);
    drain();
`else
    expect_val("unaligned_pc", SEL_PC, 64'h1002);
    drain();
`endif

    // Reset in the middle of a stalled fetch
    PS = 2'b01; IL = 1'b1; imem_ack = 1'b0; imem_data = 32'h12345678;
    tick();
    reset = 1'b0;
    #1;
    expect_val("midrst_pc", SEL_PC, 64'h40);
    expect_val("midrst_ir", SEL_IR, 64'h0);
    expect_val("midrst_status", SEL_STAT, 64'h0);
`ifdef PC_ALIGN_CHECK_EN
    expect_val("midrst_mis", SEL_MIS, 64'h0);
`endif
    drain();
    tick();
    IL = 1'b0; PS = 2'b00; imem_ack = 1'b1;
    reset = 1'b1;
    tick();
    expect_val("late_ack_ir", SEL_IR, 64'h0);
    expect_val("late_ack_pc", SEL_PC, 64'h40);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
